// File: rtl/spi_master_64_if.sv
// Host-side bus of the 64-bit SPI master: frame request/response plus the SPI pins.
// master = the SPI master block itself; slave = the host/peer driving and watching it.
interface spi_master_64_if #(
   parameter int unsigned DATA_W = 64
);
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rx_data;
   logic              sclk;
   logic              cs_n;
   logic              mosi;
   logic              miso;

   modport master (
      input  start, tx_data, miso,
      output busy, done, rx_data, sclk, cs_n, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  busy, done, rx_data, sclk, cs_n, mosi
   );
endinterface

// File: rtl/spi_master_64.sv
// SPI Mode 0 (CPOL=0, CPHA=0) master running one full-duplex DATA_W-bit frame per start.
// Every output is a flop; miso is sampled on the clk edge that raises sclk.
module spi_master_64 #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned DATA_W  = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   spi_master_64_if.master  bus
);

   localparam int unsigned HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } state_e;

   state_e            state_q;
   logic [HC_W-1:0]   hc_q;
   logic [6:0]        bit_cnt_q;
   logic [DATA_W-1:0] tx_sh_q;
   logic [DATA_W-1:0] rx_sh_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              sclk_q;
   logic              cs_n_q;
   logic              mosi_q;
   logic              busy_q;
   logic              done_q;
   logic              hc_last;

   assign hc_last = (hc_q == HC_W'(CLK_DIV - 1));

   // tx_sh_q holds the bits still to be sent, MSB-aligned: the MSB goes straight
   // to mosi at acceptance, so the shifter is loaded pre-shifted by one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         hc_q      <= '0;
         bit_cnt_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         hc_q   <= hc_last ? '0 : hc_q + HC_W'(1);
         unique case (state_q)
            IDLE: begin
               hc_q <= '0;
               if (bus.start) begin
                  tx_sh_q   <= {bus.tx_data[DATA_W-2:0], 1'b0};
                  mosi_q    <= bus.tx_data[DATA_W-1];
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  cs_n_q    <= 1'b0;
                  state_q   <= SETUP;
               end
            end
            SETUP, LOW: begin
               if (hc_last) begin
                  sclk_q  <= 1'b1;
                  rx_sh_q <= {rx_sh_q[DATA_W-2:0], bus.miso};
                  state_q <= HIGH;
               end
            end
            HIGH: begin
               if (hc_last) begin
                  sclk_q    <= 1'b0;
                  bit_cnt_q <= bit_cnt_q + 7'd1;
                  if (bit_cnt_q == 7'(DATA_W - 1)) begin
                     mosi_q  <= 1'b0;
                     state_q <= HOLD;
                  end else begin
                     mosi_q  <= tx_sh_q[DATA_W-1];
                     tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
                     state_q <= LOW;
                  end
               end
            end
            HOLD: begin
               if (hc_last) begin
                  cs_n_q    <= 1'b1;
                  rx_data_q <= rx_sh_q;
                  done_q    <= 1'b1;
                  state_q   <= GAP;
               end
            end
            GAP: begin
               if (hc_last) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sclk    = sclk_q;
   assign bus.cs_n    = cs_n_q;
   assign bus.mosi    = mosi_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;

endmodule
